quadrature_step_decoder: RTL

Decodes a two-phase quadrature signal pair (A/B, asynchronous to clock) into per-step direction and strobe outputs. The outputs drive the up_down and run inputs of the team's up/down counter directly, so the counter tracks encoder position. The block includes input synchronizers, a stability filter, illegal-transition detection and a sticky error flag.

---
 rtl/quadrature_step_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B decoder: synchronizes and filters the encoder pins, then emits one
// registered run/up_down step per accepted Gray transition plus illegal-jump error flags.
module quadrature_step_decoder #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 3,
   parameter int unsigned FILTER_WIDTH  = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic enc_a,
   input  logic enc_b,
   input  logic enable,
   input  logic error_ack,
   output logic up_down,
   output logic run,
   output logic step_error,
   output logic error_sticky
);

   localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + FILTER_CYCLES;
   localparam int unsigned SETTLE_WIDTH  = $clog2(SETTLE_CYCLES + 1);

   logic [SYNC_STAGES-1:0]  sync_a;
   logic [SYNC_STAGES-1:0]  sync_b;
   logic [1:0]              sample;
   logic [1:0]              held;
   logic [1:0]              state;
   logic [FILTER_WIDTH-1:0] count;
   logic [FILTER_WIDTH-1:0] count_next;
   logic [SETTLE_WIDTH-1:0] settle;
   logic                    init;
   logic                    accept;
   logic                    settled;
   logic                    live;
   logic [1:0]              delta;
   logic                    step_up;
   logic                    step_down;
   logic                    step_bad;

   // Map Gray code 00,01,11,10 onto positions 0..3 so a step is a modulo-4 difference.
   function automatic logic [1:0] position(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   assign sample = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

   always_comb begin
      count_next = '0;
      if (sample == state) begin
         count_next = '0;
      end else if (sample != held) begin
         count_next = FILTER_WIDTH'(1);
      end else begin
         count_next = count + FILTER_WIDTH'(1);
      end
   end

   // The init window also closes once the pins are seen resting at the reset state
   // long enough for the synchronizer to flush and the filter to confirm them.
   always_comb begin
      accept    = (sample != state) && (count_next >= FILTER_WIDTH'(FILTER_CYCLES));
      settled   = (sample == state) && ((settle + SETTLE_WIDTH'(1)) == SETTLE_WIDTH'(SETTLE_CYCLES));
      live      = accept && !init && enable;
      delta     = position(sample) - position(state);
      step_up   = live && (delta == 2'd1);
      step_down = live && (delta == 2'd3);
      step_bad  = live && (delta == 2'd2);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         sync_a       <= '0;
         sync_b       <= '0;
         held         <= '0;
         state        <= '0;
         count        <= '0;
         settle       <= '0;
         init         <= 1'b1;
         run          <= 1'b0;
         step_error   <= 1'b0;
         up_down      <= 1'b1;
         error_sticky <= 1'b0;
      end else begin
         sync_a     <= {sync_a[SYNC_STAGES-2:0], enc_a};
         sync_b     <= {sync_b[SYNC_STAGES-2:0], enc_b};
         held       <= sample;
         run        <= step_up || step_down;
         step_error <= step_bad;

         if (accept) begin
            state <= sample;
            count <= '0;
         end else begin
            count <= count_next;
         end

         if (init) begin
            settle <= (sample == state) ? settle + SETTLE_WIDTH'(1) : '0;
            if (accept || settled) begin
               init <= 1'b0;
            end
         end

         if (step_up) begin
            up_down <= 1'b1;
         end else if (step_down) begin
            up_down <= 1'b0;
         end

         // A new error on the acknowledge edge keeps the flag set.
         if (step_bad) begin
            error_sticky <= 1'b1;
         end else if (error_ack) begin
            error_sticky <= 1'b0;
         end
      end
   end

endmodule
